// File: rtl/sc_sched.sv
// Successive-cancellation polar decoder scheduler: sequences f/g PE operations
// over the decoding tree, makes bit decisions and tracks partial sums.
module sc_sched #(
    parameter int unsigned LOG_N = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [(1<<LOG_N)-1:0]   frozen,
    output logic                    pe_en,
    output logic                    pe_fg,
    output logic                    pe_usum,
    output logic [1:0]              pe_stage,
    output logic [2:0]              pe_idx,
    input  logic                    pe_sign,
    output logic [(1<<LOG_N)-1:0]   u_hat,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned N = 1 << LOG_N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [LOG_N-1:0] cur_i;
    logic [N-1:0]     frz;

    logic [N-1:0]     u_nxt;
    logic             fin;
    int unsigned      ni;
    int unsigned      ns;
    int unsigned      nj;
    logic             nfg;
    logic             nusum;

    // Index of the lowest set bit; bit 0 of the codeword starts at the root.
    function automatic int unsigned lsb_of(input int unsigned v);
        int unsigned r;
        r = LOG_N - 1;
        for (int k = LOG_N - 1; k >= 0; k--) begin
            if (((v >> k) & 32'd1) != 32'd0) r = k;
        end
        return r;
    endfunction

    // Bit j of u_blk * G(2^s): XOR of block bits k whose index covers j.
    // The decoded bits themselves serve as the partial-sum store.
    function automatic logic calc_usum(input logic [N-1:0] u, input int unsigned i,
                                       input int unsigned s, input int unsigned j);
        logic acc;
        int   base;
        int   len;
        acc  = 1'b0;
        len  = int'(32'd1 << s);
        base = int'(i) - len;
        for (int k = 0; k < int'(N); k++) begin
            if (k < len && base + k >= 0 && base + k < int'(N) && ((k & int'(j)) == int'(j)))
                acc = acc ^ u[LOG_N'(base + k)];
        end
        return acc;
    endfunction

    // Decision for the current op and the next op of the schedule.
    always_comb begin
        u_nxt = u_hat;
        fin   = 1'b0;
        ni    = 32'(cur_i);
        ns    = 32'(pe_stage);
        nj    = 32'(pe_idx);
        if (pe_stage == 2'd0) begin
            u_nxt[cur_i] = ~frz[cur_i] & pe_sign;
            if (cur_i == LOG_N'(N - 1)) begin
                fin = 1'b1;
            end else begin
                ni = ni + 32'd1;
                ns = lsb_of(ni);
                nj = 32'd0;
            end
        end else if (nj == (32'd1 << ns) - 32'd1) begin
            ns = ns - 32'd1;
            nj = 32'd0;
        end else begin
            nj = nj + 32'd1;
        end
        nfg   = ((ni >> ns) & 32'd1) != 32'd0;
        nusum = nfg & calc_usum(u_nxt, ni, ns, nj);
    end

    // Control FSM with registered PE command and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_i    <= '0;
            frz      <= '0;
            u_hat    <= '0;
            pe_en    <= 1'b0;
            pe_fg    <= 1'b0;
            pe_usum  <= 1'b0;
            pe_stage <= 2'd0;
            pe_idx   <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        pe_en    <= 1'b1;
                        cur_i    <= '0;
                        pe_stage <= 2'(LOG_N - 1);
                        pe_idx   <= 3'd0;
                        pe_fg    <= 1'b0;
                        pe_usum  <= 1'b0;
                        u_hat    <= '0;
                        frz      <= frozen;
                    end
                end
                RUN: begin
                    u_hat <= u_nxt;
                    if (fin) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pe_en    <= 1'b0;
                        pe_fg    <= 1'b0;
                        pe_usum  <= 1'b0;
                        pe_stage <= 2'd0;
                        pe_idx   <= 3'd0;
                        cur_i    <= '0;
                    end else begin
                        cur_i    <= LOG_N'(ni);
                        pe_stage <= 2'(ns);
                        pe_idx   <= 3'(nj);
                        pe_fg    <= nfg;
                        pe_usum  <= nusum;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_sched.sv
// Scoreboard bench for sc_sched at N = 8: hand-written schedule table, expected
// ops queued at stimulus time and checked by an independent monitor.
module tb_sc_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] frozen;
    logic       pe_en, pe_fg, pe_usum;
    logic [1:0] pe_stage;
    logic [2:0] pe_idx;
    logic       pe_sign;
    logic [7:0] u_hat;
    logic       busy, done;

    int total = 0;
    int bad   = 0;

    logic [7:0] sign_mask = 8'h00;
    bit         sign_all  = 1'b0;
    int         dec_cnt   = 0;
    logic [7:0] q[$];

    // {bit i, fg, stage, idx} in issue order for N = 8
    logic [8:0] sched [24] = '{
        {3'd0,1'b0,2'd2,3'd0}, {3'd0,1'b0,2'd2,3'd1}, {3'd0,1'b0,2'd2,3'd2}, {3'd0,1'b0,2'd2,3'd3},
        {3'd0,1'b0,2'd1,3'd0}, {3'd0,1'b0,2'd1,3'd1}, {3'd0,1'b0,2'd0,3'd0},
        {3'd1,1'b1,2'd0,3'd0},
        {3'd2,1'b1,2'd1,3'd0}, {3'd2,1'b1,2'd1,3'd1}, {3'd2,1'b0,2'd0,3'd0},
        {3'd3,1'b1,2'd0,3'd0},
        {3'd4,1'b1,2'd2,3'd0}, {3'd4,1'b1,2'd2,3'd1}, {3'd4,1'b1,2'd2,3'd2}, {3'd4,1'b1,2'd2,3'd3},
        {3'd4,1'b0,2'd1,3'd0}, {3'd4,1'b0,2'd1,3'd1}, {3'd4,1'b0,2'd0,3'd0},
        {3'd5,1'b1,2'd0,3'd0},
        {3'd6,1'b1,2'd1,3'd0}, {3'd6,1'b1,2'd1,3'd1}, {3'd6,1'b0,2'd0,3'd0},
        {3'd7,1'b1,2'd0,3'd0}
    };

    sc_sched #(.LOG_N(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .frozen   (frozen),
        .pe_en    (pe_en),
        .pe_fg    (pe_fg),
        .pe_usum  (pe_usum),
        .pe_stage (pe_stage),
        .pe_idx   (pe_idx),
        .pe_sign  (pe_sign),
        .u_hat    (u_hat),
        .busy     (busy),
        .done     (done)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Kernel products written out per stage for N = 8
    function automatic logic xbit(input logic [7:0] u, input int i, input int s, input int j);
        int b;
        case (s)
            0: return u[i-1];
            1: return (j == 0) ? (u[i-2] ^ u[i-1]) : u[i-1];
            default: begin
                b = i - 4;
                case (j)
                    0: return u[b] ^ u[b+1] ^ u[b+2] ^ u[b+3];
                    1: return u[b+1] ^ u[b+3];
                    2: return u[b+2] ^ u[b+3];
                    default: return u[b+3];
                endcase
            end
        endcase
    endfunction

    task automatic push_ops(input logic [7:0] u, input int n);
        logic [8:0] e;
        logic       us;
        for (int k = 0; k < n; k++) begin
            e  = sched[k];
            us = e[5] ? xbit(u, int'(e[8:6]), int'(e[4:3]), int'(e[2:0])) : 1'b0;
            q.push_back({1'b0, e[5], us, e[4:3], e[2:0]});
        end
    endtask

    // PE model: returns the scripted sign for each decision in order
    initial forever begin
        @(negedge clk);
        if (!rst_n || (start && !busy)) dec_cnt = 0;
        pe_sign = sign_all;
        if (pe_en && pe_stage == 2'd0) begin
            pe_sign = sign_all | sign_mask[dec_cnt[2:0]];
            dec_cnt++;
        end
    end

    // Monitor: pop and compare every issued op; idle command must be zero
    initial forever begin
        logic [7:0] exp;
        @(negedge clk);
        if (rst_n) begin
            if (pe_en) begin
                if (q.size() == 0) begin
                    chk("extra_op", {24'd0, 1'b1, pe_fg, pe_usum, pe_stage, pe_idx}, 32'd0);
                end else begin
                    exp = q.pop_front();
                    chk("pe_op", {24'd0, 1'b0, pe_fg, pe_usum, pe_stage, pe_idx}, {24'd0, exp});
                end
            end else begin
                chk("pe_idle", {26'd0, pe_fg, pe_usum, pe_stage, pe_idx}, 32'd0);
            end
        end
    end

    // Full decode; caller stands just after a rising edge
    task automatic run_decode(input logic [7:0] frz, input logic [7:0] mask,
                              input bit all, input bit restart);
        logic [7:0] u_exp;
        int         cyc;
        u_exp     = ~frz & (all ? 8'hFF : mask);
        sign_mask = mask;
        sign_all  = all;
        frozen    = frz;
        push_ops(u_exp, 24);
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        frozen = ~frz;
        cyc = 0;
        while (busy && cyc < 100) begin
            start = restart && (cyc == 10);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("busy_len", cyc, 24);
        chk("done_hi", {31'd0, done}, 32'd1);
        chk("u_hat", {24'd0, u_hat}, {24'd0, u_exp});
        chk("ops_left", q.size(), 0);
        if (restart) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("no_requeue", {29'd0, done, busy, pe_en}, 32'd0);
            @(posedge clk); #1;
            chk("still_idle", {29'd0, done, busy, pe_en}, 32'd0);
        end else begin
            @(posedge clk); #1;
            chk("done_pulse", {31'd0, done}, 32'd0);
        end
        chk("u_hold", {24'd0, u_hat}, {24'd0, u_exp});
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        frozen  = 8'h00;
        pe_sign = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {15'd0, busy, done, pe_en, pe_fg, pe_usum, pe_stage, pe_idx, u_hat}, 32'd0);
        rst_n = 1'b1;

        run_decode(8'hFF, 8'h00, 1'b1, 1'b0);
        run_decode(8'h00, 8'hFF, 1'b0, 1'b0);
        run_decode(8'h17, 8'hA0, 1'b0, 1'b0);
        run_decode(8'h35, 8'h5A, 1'b0, 1'b1);

        // Mid-run asynchronous reset during op 12
        frozen    = 8'h3C;
        sign_mask = 8'hC3;
        sign_all  = 1'b0;
        push_ops(8'hC3, 12);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst", {15'd0, busy, done, pe_en, pe_fg, pe_usum, pe_stage, pe_idx, u_hat}, 32'd0);
        chk("rst_ops_left", q.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_decode(8'h0F, 8'hF0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
